axis_deadlock_watchdog: RTL and testbench
=========================================

# axis_deadlock_watchdog

Parametrised deadlock monitor for an HLS-generated top-level. One instance watches one dataflow/pipeline instance. It combines per-AXIS-channel block flags with the block flags of its parallel and sequential sub-instances. A block condition must persist for a programmable number of cycles before it is reported. The block then identifies the first offending source and can hold the report sticky until software or the testbench clears it.

## Interface
Parameters:
- N_AXIS, 15, number of AXIS block inputs
- AXIS_MASK, 15'h7FFC, per-channel enable; a 0 bit ignores that channel
- N_SUB_PAR, 0, number of parallel sub-instance block inputs (0 = none)
- N_SUB_SEQ, 0, number of sequential sub-instance block inputs (0 = none)
- N_IDLE, 2, number of idle inputs
- THRESH, 16, consecutive raw-block cycles required to report (1..2^CNT_W-1)
- CNT_W, 8, persistence counter width
- STICKY, 0, 1 = report held until clear/reset

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- axis_block_sigs  in  N_AXIS  per-channel AXIS stall flags
- sub_par_block  in  max(N_SUB_PAR,1)  parallel sub-instance block flags
- sub_seq_block  in  max(N_SUB_SEQ,1)  sequential sub-instance block flags
- inst_idle_sigs  in  N_IDLE  instance idle flags
- clear  in  1  drop report, zero counter and capture
- block  out  1  registered deadlock report
- block_raw  out  1  registered unfiltered block condition
- block_src  out  2  source of report: 0 none, 1 axis, 2 sub_par, 3 sub_seq
- block_chan  out  IDX_W  index within the source (IDX_W = clog2(max(N_AXIS,N_SUB_PAR,N_SUB_SEQ,2)))
- stall_cnt  out  CNT_W  current persistence count

## Operation
- Each term of the raw condition is evaluated combinationally every cycle.
  - axis_hit = |(axis_block_sigs & AXIS_MASK)
  - par_hit = (N_SUB_PAR>0) & (&sub_par_block), so all parallel branches must be blocked
  - seq_hit = (N_SUB_SEQ>0) & (|sub_seq_block)
  - idle_all = &inst_idle_sigs
- raw = (axis_hit | par_hit | seq_hit) & ~idle_all. A fully idle instance is never reported.
- Counter:
  - If raw, the counter increments and saturates at 2^CNT_W-1.
  - If not raw, the counter goes to 0.
- Report set: the report sets when raw is true and the counter already equals THRESH-1.
- Report drop:
  - STICKY=0: the report drops the cycle after raw falls.
  - STICKY=1: the report is held until clear or reset.
- Capture: on the set cycle (block 0->1), block_src/block_chan latch the source. They hold while block=1.
  - Source priority: axis > sub_par > sub_seq.
  - Channel: the lowest-index asserted masked axis bit, or the lowest-index asserted sub_seq bit.
  - For sub_par, block_chan = 0.
- clear:
  - Zeroes block, counter, block_src and block_chan next cycle.
  - Wins over a same-cycle set.
  - The counter restarts counting from the following cycle.
- THRESH=1, STICKY=0 reproduces the one-cycle registered monitor of the previous generation.

## Timing
- Reset values: block=0, block_raw=0, block_src=0, block_chan=0, stall_cnt=0.
- block_raw = raw delayed 1 cycle.
- Latency: if raw first goes high in cycle t and stays high, block is 1 from cycle t+THRESH.
- Any single low cycle of raw before the threshold restarts the count from 0.
- Saturation: the counter holds at max. block stays 1 while raw holds.
- Reset asserted mid-report: all outputs at reset values the next cycle, regardless of STICKY.
- Simultaneous raw fall and threshold reach are impossible; set requires raw in the same cycle.

## Structure
- Shared package deadlock_mon_pkg holds:
  - block_src encodings (SRC_NONE, SRC_AXIS, SRC_PAR, SRC_SEQ)
  - a clog2 helper used for IDX_W
- Sub-module lsb_priority_enc (parametrised width, outputs index and valid) serves two uses:
  - one instance for the masked axis vector
  - one instance for sub_seq_block
- Parameter checks at elaboration:
  - THRESH >= 1
  - THRESH < 2^CNT_W
  - AXIS_MASK width == N_AXIS

## Test plan
- Defaults; hold axis_block_sigs=15'h0010 for 20 cycles from t0 -> block=1 at t0+16, block_src=1, block_chan=4; drop to 0 -> block=0 one cycle later.
- axis_block_sigs=15'h0003 (masked bits only) for 40 cycles -> block, block_raw stay 0, stall_cnt stays 0.
- Pulse bit 6 for 10 cycles, gap 1 cycle, pulse 10 more -> block never asserts; stall_cnt peaks at 10.
- STICKY=1, THRESH=4; bit 2 high 6 cycles then low -> block stays 1; assert clear for 1 cycle -> block=0, block_chan=0 next cycle.
- N_SUB_PAR=2, N_SUB_SEQ=3, THRESH=1:
  - sub_par=2'b01 -> no block.
  - sub_par=2'b11 -> block_src=2 after 1 cycle.
  - sub_seq=3'b110 alone -> block_src=3, block_chan=1.
  - Repeat with inst_idle_sigs=2'b11 -> no block.
- Reset asserted while block=1 (STICKY=1) -> all outputs 0 next cycle; axis_block_sigs still high -> re-report THRESH cycles after reset release.

Source files
------------

// File: rtl/deadlock_mon_pkg.sv
// Shared types and elaboration helpers for the deadlock monitor family.
// Holds the report-source encoding and width helpers used by both interface and RTL.
package deadlock_mon_pkg;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_AXIS = 2'd1,
    SRC_PAR  = 2'd2,
    SRC_SEQ  = 2'd3
  } block_src_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Channel index width, wide enough for the largest source and never below one bit.
  function automatic int idx_width(input int n_axis, input int n_par, input int n_seq);
    return clog2(max2(max2(n_axis, n_par), max2(n_seq, 2)));
  endfunction

endpackage

// File: rtl/axis_deadlock_watchdog_if.sv
// Block-flag inputs and deadlock-report outputs of one watched dataflow instance.
// master drives the flags and reads the report; slave is the watchdog itself.
interface axis_deadlock_watchdog_if #(
  parameter int N_AXIS    = 15,
  parameter int N_SUB_PAR = 0,
  parameter int N_SUB_SEQ = 0,
  parameter int N_IDLE    = 2,
  parameter int CNT_W     = 8
);

  localparam int PAR_W = deadlock_mon_pkg::max2(N_SUB_PAR, 1);
  localparam int SEQ_W = deadlock_mon_pkg::max2(N_SUB_SEQ, 1);
  localparam int IDX_W = deadlock_mon_pkg::idx_width(N_AXIS, N_SUB_PAR, N_SUB_SEQ);

  logic [N_AXIS-1:0]           axis_block_sigs;
  logic [PAR_W-1:0]            sub_par_block;
  logic [SEQ_W-1:0]            sub_seq_block;
  logic [N_IDLE-1:0]           inst_idle_sigs;
  logic                        clear;
  logic                        block;
  logic                        block_raw;
  deadlock_mon_pkg::block_src_e block_src;
  logic [IDX_W-1:0]            block_chan;
  logic [CNT_W-1:0]            stall_cnt;

  modport master (
    output axis_block_sigs, sub_par_block, sub_seq_block, inst_idle_sigs, clear,
    input  block, block_raw, block_src, block_chan, stall_cnt
  );

  modport slave (
    input  axis_block_sigs, sub_par_block, sub_seq_block, inst_idle_sigs, clear,
    output block, block_raw, block_src, block_chan, stall_cnt
  );

endinterface

// File: rtl/lsb_priority_enc.sv
// Lowest-index priority encoder: idx is the lowest set bit of vec, valid when any bit is set.
// idx is 0 when vec is all zero.
module lsb_priority_enc #(
  parameter int W  = 8,
  parameter int IW = 3
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // NOTE: idx gets a default before the loop so always_comb never infers a latch.
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

  assign valid = |vec;

endmodule

// File: rtl/axis_deadlock_watchdog.sv
// Deadlock watchdog for one HLS dataflow instance: filters the combined block condition
// through a persistence counter and captures the first offending source on report.
module axis_deadlock_watchdog
  import deadlock_mon_pkg::*;
#(
  parameter int N_AXIS    = 15,
  parameter     AXIS_MASK = 15'h7FFC,
  parameter int N_SUB_PAR = 0,
  parameter int N_SUB_SEQ = 0,
  parameter int N_IDLE    = 2,
  parameter int THRESH    = 16,
  parameter int CNT_W     = 8,
  parameter bit STICKY    = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset,
  axis_deadlock_watchdog_if.slave bus
);

  localparam int SEQ_W = max2(N_SUB_SEQ, 1);
  localparam int IDX_W = idx_width(N_AXIS, N_SUB_PAR, N_SUB_SEQ);

  localparam logic [N_AXIS-1:0] MASK      = N_AXIS'(AXIS_MASK);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  THRESH_M1 = CNT_W'(THRESH - 1);
  localparam bit                HAS_PAR   = (N_SUB_PAR > 0);
  localparam bit                HAS_SEQ   = (N_SUB_SEQ > 0);

  if (THRESH < 1) begin : g_bad_thresh_low
    $error("axis_deadlock_watchdog: THRESH must be at least 1");
  end
  if (THRESH >= (1 << CNT_W)) begin : g_bad_thresh_high
    $error("axis_deadlock_watchdog: THRESH must be below 2**CNT_W");
  end
  if ($bits(AXIS_MASK) != N_AXIS) begin : g_bad_mask
    $error("axis_deadlock_watchdog: AXIS_MASK width must equal N_AXIS");
  end

  logic [N_AXIS-1:0] axis_masked;
  logic [IDX_W-1:0]  axis_idx;
  logic [IDX_W-1:0]  seq_idx;
  logic              axis_hit;
  logic              seq_any;
  logic              par_hit;
  logic              seq_hit;
  logic              idle_all;
  logic              raw;

  assign axis_masked = bus.axis_block_sigs & MASK;

  lsb_priority_enc #(.W(N_AXIS), .IW(IDX_W)) u_axis_enc (
    .vec   (axis_masked),
    .idx   (axis_idx),
    .valid (axis_hit)
  );

  lsb_priority_enc #(.W(SEQ_W), .IW(IDX_W)) u_seq_enc (
    .vec   (bus.sub_seq_block),
    .idx   (seq_idx),
    .valid (seq_any)
  );

  // A parallel region is only stuck when every branch is stuck.
  assign par_hit  = HAS_PAR & (&bus.sub_par_block);
  assign seq_hit  = HAS_SEQ & seq_any;
  assign idle_all = &bus.inst_idle_sigs;
  assign raw      = (axis_hit | par_hit | seq_hit) & ~idle_all;

  block_src_e       cap_src;
  logic [IDX_W-1:0] cap_chan;

  always_comb begin
    cap_src  = SRC_NONE;
    cap_chan = '0;
    if (axis_hit) begin
      cap_src  = SRC_AXIS;
      cap_chan = axis_idx;
    end else if (par_hit) begin
      cap_src  = SRC_PAR;
    end else if (seq_hit) begin
      cap_src  = SRC_SEQ;
      cap_chan = seq_idx;
    end
  end

  logic [CNT_W-1:0] cnt_q;
  logic             blk_q;
  logic             raw_q;
  block_src_e       src_q;
  logic [IDX_W-1:0] chan_q;
  logic             blk_next;

  // Set needs raw in this cycle; once up, the report survives while raw holds or when sticky.
  assign blk_next = (raw & (cnt_q == THRESH_M1)) | (blk_q & (STICKY | raw));

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      blk_q  <= 1'b0;
      raw_q  <= 1'b0;
      src_q  <= SRC_NONE;
      chan_q <= '0;
    end else begin
      raw_q <= raw;
      if (bus.clear) begin
        cnt_q  <= '0;
        blk_q  <= 1'b0;
        src_q  <= SRC_NONE;
        chan_q <= '0;
      end else begin
        if (!raw)                 cnt_q <= '0;
        else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
        blk_q <= blk_next;
        // Capture only on the rising report; a dropped report reads as no source.
        if (!blk_next) begin
          src_q  <= SRC_NONE;
          chan_q <= '0;
        end else if (!blk_q) begin
          src_q  <= cap_src;
          chan_q <= cap_chan;
        end
      end
    end
  end

  assign bus.block      = blk_q;
  assign bus.block_raw  = raw_q;
  assign bus.block_src  = src_q;
  assign bus.block_chan = chan_q;
  assign bus.stall_cnt  = cnt_q;

endmodule

// File: tb/tb_axis_deadlock_watchdog.sv
// Scoreboard bench for axis_deadlock_watchdog: three configurations share one clock,
// a run-length reference model pushes expected outputs that are popped after each edge.
module tb_axis_deadlock_watchdog;

  localparam logic [14:0] MASK = 15'h7FFC;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  axis_deadlock_watchdog_if #(.N_AXIS(15)) if0 ();
  axis_deadlock_watchdog_if #(.N_AXIS(15)) if1 ();
  axis_deadlock_watchdog_if #(.N_AXIS(15), .N_SUB_PAR(2), .N_SUB_SEQ(3)) if2 ();

  axis_deadlock_watchdog u_dut0 (.clock(clock), .reset(reset), .bus(if0));
  axis_deadlock_watchdog #(.THRESH(4), .STICKY(1'b1)) u_dut1 (
    .clock(clock), .reset(reset), .bus(if1));
  axis_deadlock_watchdog #(.N_SUB_PAR(2), .N_SUB_SEQ(3), .THRESH(1)) u_dut2 (
    .clock(clock), .reset(reset), .bus(if2));

  int c_thresh [3] = '{16, 4, 1};
  bit c_sticky [3] = '{1'b0, 1'b1, 1'b0};

  int          sel;
  logic [14:0] s_axis;
  logic [1:0]  s_par;
  logic [2:0]  s_seq;
  logic [1:0]  s_idle;
  logic        s_clear;

  // Reference state: run length of consecutive raw cycles, not a saturating counter.
  int          m_run;
  logic        m_blk, m_raw;
  logic [1:0]  m_src;
  logic [3:0]  m_chan;

  logic [15:0] exp_q[$];
  logic [15:0] last_got;
  int          n_total = 0;
  int          n_bad   = 0;
  string       tag;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [3:0] lowest(input logic [14:0] v);
    for (int i = 0; i < 15; i++) if (v[i]) return 4'(i);
    return 4'd0;
  endfunction

  function automatic logic [15:0] read_dut();
    case (sel)
      0:       return {if0.block, if0.block_raw, if0.block_src, if0.block_chan, if0.stall_cnt};
      1:       return {if1.block, if1.block_raw, if1.block_src, if1.block_chan, if1.stall_cnt};
      default: return {if2.block, if2.block_raw, if2.block_src, if2.block_chan, if2.stall_cnt};
    endcase
  endfunction

  task automatic drive();
    if0.axis_block_sigs = (sel == 0) ? s_axis : 15'd0;
    if0.inst_idle_sigs  = (sel == 0) ? s_idle : 2'd0;
    if0.clear           = (sel == 0) ? s_clear : 1'b0;
    if0.sub_par_block   = 1'b0;
    if0.sub_seq_block   = 1'b0;
    if1.axis_block_sigs = (sel == 1) ? s_axis : 15'd0;
    if1.inst_idle_sigs  = (sel == 1) ? s_idle : 2'd0;
    if1.clear           = (sel == 1) ? s_clear : 1'b0;
    if1.sub_par_block   = 1'b0;
    if1.sub_seq_block   = 1'b0;
    if2.axis_block_sigs = (sel == 2) ? s_axis : 15'd0;
    if2.inst_idle_sigs  = (sel == 2) ? s_idle : 2'd0;
    if2.clear           = (sel == 2) ? s_clear : 1'b0;
    if2.sub_par_block   = (sel == 2) ? s_par : 2'd0;
    if2.sub_seq_block   = (sel == 2) ? s_seq : 3'd0;
  endtask

  task automatic model_step();
    logic [14:0] am;
    logic        ah, ph, sh, raw, nb;
    if (reset) begin
      m_run = 0; m_blk = 1'b0; m_raw = 1'b0; m_src = 2'd0; m_chan = 4'd0;
      return;
    end
    am    = s_axis & MASK;
    ah    = |am;
    ph    = (sel == 2) && (&s_par);
    sh    = (sel == 2) && (|s_seq);
    raw   = (ah || ph || sh) && !(&s_idle);
    m_raw = raw;
    if (s_clear) begin
      m_run = 0; m_blk = 1'b0; m_src = 2'd0; m_chan = 4'd0;
      return;
    end
    m_run = raw ? m_run + 1 : 0;
    nb = c_sticky[sel] ? (m_blk || m_run >= c_thresh[sel]) : (m_run >= c_thresh[sel]);
    if (!nb) begin
      m_src = 2'd0; m_chan = 4'd0;
    end else if (!m_blk) begin
      if (ah)      begin m_src = 2'd1; m_chan = lowest(am); end
      else if (ph) begin m_src = 2'd2; m_chan = 4'd0; end
      else         begin m_src = 2'd3; m_chan = lowest({12'd0, s_seq}); end
    end
    m_blk = nb;
  endtask

  // One clock: drive inputs, push the model's prediction, pop and compare after the edge.
  task automatic tick();
    logic [7:0] cnt_exp;
    drive();
    model_step();
    cnt_exp = (m_run > 255) ? 8'hFF : 8'(m_run);
    exp_q.push_back({m_blk, m_raw, m_src, m_chan, cnt_exp});
    @(posedge clock);
    #1;
    last_got = read_dut();
    check(tag, last_got, exp_q.pop_front());
  endtask

  task automatic idle_inputs();
    s_axis = '0; s_par = '0; s_seq = '0; s_idle = '0; s_clear = 1'b0;
  endtask

  task automatic do_reset(input int which);
    sel = which;
    idle_inputs();
    tag   = "reset";
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int first;
    int peak;
    bit seen;
    reset = 1'b1;
    sel   = 0;
    idle_inputs();
    m_run = 0; m_blk = 1'b0; m_raw = 1'b0; m_src = 2'd0; m_chan = 4'd0;
    drive();

    // Defaults: unmasked bit 4 stalls; report after 16 cycles, drops one cycle after release.
    do_reset(0);
    tag = "s1_hold"; s_axis = 15'h0010; first = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (first < 0 && last_got[15]) first = k;
    end
    check("s1_latency", 16'(first), 16'd16);
    check("s1_src_chan", {10'd0, last_got[13:8]}, {10'd0, 2'd1, 4'd4});
    tag = "s1_drop"; s_axis = '0;
    tick();
    check("s1_block_low", {15'd0, last_got[15]}, 16'd0);
    tick();

    // Only masked-off channels stalling: never raw, never counting.
    tag = "s2_masked"; s_axis = 15'h0003; seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (last_got[15] || last_got[14] || last_got[7:0] != 8'd0) seen = 1'b1;
    end
    check("s2_quiet", {15'd0, seen}, 16'd0);

    // Two 10-cycle pulses split by one low cycle never reach a threshold of 16.
    tag = "s3_pulse"; peak = 0; seen = 1'b0;
    for (int k = 0; k < 21; k++) begin
      s_axis = (k == 10) ? 15'h0000 : 15'h0040;
      tick();
      if (int'(last_got[7:0]) > peak) peak = int'(last_got[7:0]);
      if (last_got[15]) seen = 1'b1;
    end
    s_axis = '0;
    tick();
    check("s3_peak", 16'(peak), 16'd10);
    check("s3_no_block", {15'd0, seen}, 16'd0);

    // Long stall: counter saturates, report holds.
    tag = "s7_sat"; s_axis = 15'h4000;
    for (int k = 0; k < 270; k++) tick();
    check("s7_cnt_max", {8'd0, last_got[7:0]}, 16'h00FF);
    s_axis = '0;
    tick();

    // Sticky, THRESH=4: report outlives the stall until clear.
    do_reset(1);
    tag = "s4_sticky"; s_axis = 15'h0004;
    for (int k = 0; k < 6; k++) tick();
    s_axis = '0;
    for (int k = 0; k < 5; k++) tick();
    check("s4_held", {15'd0, last_got[15]}, 16'd1);
    tag = "s4_clear"; s_clear = 1'b1;
    tick();
    s_clear = 1'b0;
    check("s4_cleared", {10'd0, last_got[15], last_got[13:8]}, 16'd0);
    tick();

    // Sub-instances with THRESH=1.
    do_reset(2);
    tag = "s5_par01"; s_par = 2'b01;
    for (int k = 0; k < 3; k++) tick();
    tag = "s5_par11"; s_par = 2'b11;
    tick();
    check("s5_par_src", {14'd0, last_got[13:12]}, 16'd2);
    tick();
    tag = "s5_prio"; s_axis = 15'h0100;
    tick();
    s_axis = '0; s_par = '0;
    tick();
    tag = "s5_seq"; s_seq = 3'b110;
    tick();
    check("s5_seq_src_chan", {10'd0, last_got[13:8]}, {10'd0, 2'd3, 4'd1});
    tick();
    s_seq = '0;
    tick();
    tag = "s5_idle"; s_idle = 2'b11; s_par = 2'b11; s_seq = 3'b110; s_axis = 15'h0010;
    for (int k = 0; k < 3; k++) tick();
    check("s5_idle_block", {14'd0, last_got[15:14]}, 16'd0);
    idle_inputs();
    tick();

    tag = "s5_random";
    for (int k = 0; k < 300; k++) begin
      s_axis  = ($urandom_range(0, 3) == 0) ? 15'($urandom) : 15'd0;
      s_par   = 2'($urandom);
      s_seq   = ($urandom_range(0, 1) == 1) ? 3'($urandom) : 3'd0;
      s_idle  = ($urandom_range(0, 5) == 0) ? 2'b11 : 2'($urandom);
      s_clear = ($urandom_range(0, 9) == 0);
      tick();
    end
    idle_inputs();
    tick();

    // Reset mid-report on sticky instance, stall persists, re-report 4 cycles after release.
    do_reset(1);
    tag = "s6_pre"; s_axis = 15'h0004;
    for (int k = 0; k < 6; k++) tick();
    tag = "s6_reset"; reset = 1'b1;
    tick();
    check("s6_reset_out", last_got, 16'd0);
    reset = 1'b0;
    tag = "s6_rerun"; first = -1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (first < 0 && last_got[15]) first = k;
    end
    check("s6_relatency", 16'(first), 16'd4);

    tag = "s6_random";
    for (int k = 0; k < 300; k++) begin
      s_axis  = ($urandom_range(0, 4) != 0) ? 15'($urandom) & 15'h0E0F : 15'd0;
      s_idle  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'b00;
      s_clear = ($urandom_range(0, 29) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
